// File: rtl/audio_synth_pkg.sv
// Shared constants for the tone synthesiser: waveform codes, mixer FSM states, clog2.
package audio_synth_pkg;

  localparam logic [1:0] WAVE_SAW    = 2'd0;
  localparam logic [1:0] WAVE_SQUARE = 2'd1;
  localparam logic [1:0] WAVE_TRI    = 2'd2;
  localparam logic [1:0] WAVE_OFF    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_SAT  = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/synth_wave_shape.sv
// Combinational phase-to-sample shaper (saw, square, triangle, off); one instance
// is shared across all channels by the mixer.
module synth_wave_shape
  import audio_synth_pkg::*;
#(
  parameter int PW = 32,
  parameter int DW = 24
) (
  input  logic [PW-1:0] phase_i,
  input  logic [1:0]    mode_i,
  output logic [DW-1:0] sample_o
);

  localparam logic [DW-1:0] SQ_POS = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SQ_NEG = {1'b1, {(DW-2){1'b0}}, 1'b1};

  logic [DW-1:0] t, u;

  always_comb begin
    t = phase_i[PW-1 -: DW];
    // Second half of the period folds the ramp back down to form the triangle.
    u = phase_i[PW-2 -: DW] ^ {DW{phase_i[PW-1]}};
    sample_o = '0;
    case (mode_i)
      WAVE_SAW:    sample_o = {~t[DW-1], t[DW-2:0]};
      WAVE_SQUARE: sample_o = phase_i[PW-1] ? SQ_NEG : SQ_POS;
      WAVE_TRI:    sample_o = {~u[DW-1], u[DW-2:0]};
      default:     sample_o = '0;
    endcase
  end

endmodule

// File: rtl/audio_synth_mixer.sv
// NCH-channel phase-accumulator synth with sequential stereo mix and saturation.
// Define SYNTH_PAN_EN to add the per-channel ch_pan routing port.
module audio_synth_mixer
  import audio_synth_pkg::*;
#(
  parameter int NCH = 4,
  parameter int DW  = 24,
  parameter int PW  = 32,
  parameter int AW  = 4
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              sample_tick,
  input  logic [NCH-1:0]    ch_en,
  input  logic [NCH*PW-1:0] ch_inc,
  input  logic [NCH*2-1:0]  ch_mode,
  input  logic [NCH*AW-1:0] ch_atten,
`ifdef SYNTH_PAN_EN
  input  logic [NCH*2-1:0]  ch_pan,
`endif
  output logic [DW-1:0]     out_left,
  output logic [DW-1:0]     out_right,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              clip,
  output logic              tick_overrun,
  input  logic              clr_flags
);

  localparam int IW   = (NCH > 1) ? clog2(NCH) : 1;
  localparam int ACCW = DW + clog2(NCH) + 1;
  localparam logic signed [ACCW-1:0] MAXV = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] MINV = ~MAXV;

  logic [NCH-1:0][PW-1:0] inc_a;
  logic [NCH-1:0][1:0]    mode_a;
  logic [NCH-1:0][AW-1:0] atten_a;
  assign inc_a   = ch_inc;
  assign mode_a  = ch_mode;
  assign atten_a = ch_atten;
`ifdef SYNTH_PAN_EN
  logic [NCH-1:0][1:0] pan_a;
  assign pan_a = ch_pan;
`endif

  state_e                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [NCH-1:0][PW-1:0] phase_q, phase_d;
  logic signed [ACCW-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [DW-1:0]          out_l_q, out_l_d, out_r_q, out_r_d;
  logic                   valid_q, valid_d, clip_q, clip_d, ovr_q, ovr_d;

  logic [DW-1:0]          shaped;
  logic signed [ACCW-1:0] term;
  logic                   to_l, to_r, clip_ev;
  logic [DW:0]            sat_l, sat_r;

  synth_wave_shape #(.PW(PW), .DW(DW)) u_shape (
    .phase_i  (phase_q[idx_q]),
    .mode_i   (mode_a[idx_q]),
    .sample_o (shaped)
  );

  // Returns {clamped, value}.
  function automatic logic [DW:0] sat(input logic signed [ACCW-1:0] a);
    if (a > MAXV) return {1'b1, MAXV[DW-1:0]};
    if (a < MINV) return {1'b1, MINV[DW-1:0]};
    return {1'b0, a[DW-1:0]};
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    phase_d = phase_q;
    acc_l_d = acc_l_q;
    acc_r_d = acc_r_q;
    out_l_d = out_l_q;
    out_r_d = out_r_q;
    valid_d = valid_q;
    clip_ev = 1'b0;
    term    = $signed({{(ACCW-DW){shaped[DW-1]}}, shaped}) >>> atten_a[idx_q];
    if (!ch_en[idx_q]) term = '0;
`ifdef SYNTH_PAN_EN
    to_l = pan_a[idx_q][1];
    to_r = pan_a[idx_q][0];
`else
    to_l = 1'b1;
    to_r = 1'b1;
`endif
    sat_l = sat(acc_l_q);
    sat_r = sat(acc_r_q);
    case (state_q)
      ST_IDLE: if (sample_tick) begin
        for (int i = 0; i < NCH; i++)
          phase_d[i] = ch_en[i] ? phase_q[i] + inc_a[i] : '0;
        acc_l_d = '0;
        acc_r_d = '0;
        idx_d   = '0;
        state_d = ST_ACC;
      end
      ST_ACC: begin
        if (to_l) acc_l_d = acc_l_q + term;
        if (to_r) acc_r_d = acc_r_q + term;
        if (idx_q == IW'(NCH-1)) state_d = ST_SAT;
        else                     idx_d   = idx_q + IW'(1);
      end
      ST_SAT: begin
        out_l_d = sat_l[DW-1:0];
        out_r_d = sat_r[DW-1:0];
        clip_ev = sat_l[DW] | sat_r[DW];
        valid_d = 1'b1;
        state_d = ST_HOLD;
      end
      ST_HOLD: if (valid_q && out_ready) begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A flag event in the same cycle as clr_flags keeps the flag set.
    clip_d = (clip_q & ~clr_flags) | clip_ev;
    ovr_d  = (ovr_q & ~clr_flags) | (sample_tick && state_q != ST_IDLE);
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      phase_q <= '0;
      acc_l_q <= '0;
      acc_r_q <= '0;
      out_l_q <= '0;
      out_r_q <= '0;
      valid_q <= 1'b0;
      clip_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      acc_l_q <= acc_l_d;
      acc_r_q <= acc_r_d;
      out_l_q <= out_l_d;
      out_r_q <= out_r_d;
      valid_q <= valid_d;
      clip_q  <= clip_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_left     = out_l_q;
  assign out_right    = out_r_q;
  assign out_valid    = valid_q;
  assign clip         = clip_q;
  assign tick_overrun = ovr_q;

endmodule
